// File: rtl/hazard_unit_pkg.sv
// Shared types and helpers for the RV32 pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

    // M has priority over W; x0 is never forwarded.
    function automatic fwd_sel_t fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        fwd_sel_t sel;
        if ((rs != 5'd0) && (rs == rd_m) && we_m) begin
            sel = FWD_M;
        end else if ((rs != 5'd0) && (rs == rd_w) && we_w) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit_div_stall_fsm.sv
// Divide-stall sequencer: holds the pipeline front for DIV_CYCLES cycles,
// then pulses div_done_o for one cycle while the result leaves E.
module div_stall_fsm
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic div_e_i,
    output logic div_stall_o,
    output logic div_done_o
);

    localparam int CW = $clog2(DIV_CYCLES);

    div_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // State and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and outputs; the stall is Mealy in IDLE so it covers the
    // very cycle the divide first appears in E.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_stall_o = 1'b0;
        div_done_o  = 1'b0;
        if (rst_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_e_i) begin
                        div_stall_o = 1'b1;
                        cnt_d       = CW'(DIV_CYCLES - 2);
                        state_d     = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
                BUSY: begin
                    div_stall_o = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    // The divide is still in E here; going straight to IDLE
                    // without looking at div_e_i prevents a retrigger.
                    div_done_o = 1'b1;
                    state_d    = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Central hazard controller: combinational forwarding, load-use and branch
// handling, plus the divide stall sequencer.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] rs1_d_i,
    input  logic [4:0] rs2_d_i,
    input  logic [4:0] rs1_e_i,
    input  logic [4:0] rs2_e_i,
    input  logic [4:0] rd_e_i,
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_m_i,
    input  logic       reg_write_w_i,
    input  logic       load_e_i,
    input  logic       pc_src_e_i,
    input  logic       div_e_i,
    output logic [1:0] forward_a_e_o,
    output logic [1:0] forward_b_e_o,
    output logic       stall_f_o,
    output logic       stall_d_o,
    output logic       stall_e_o,
    output logic       flush_d_o,
    output logic       flush_e_o,
    output logic       flush_m_o,
    output logic       div_busy_o,
    output logic       div_done_o
);

    logic div_stall_s;
    logic div_done_s;
    logic lw_stall_s;

    div_stall_fsm #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_stall_fsm (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .div_e_i     (div_e_i),
        .div_stall_o (div_stall_s),
        .div_done_o  (div_done_s)
    );

    // Hazard detection and output merge; reset drains every stage.
    always_comb begin
        lw_stall_s    = load_e_i && (rd_e_i != 5'd0) &&
                        ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));
        forward_a_e_o = FWD_RF;
        forward_b_e_o = FWD_RF;
        stall_f_o     = 1'b0;
        stall_d_o     = 1'b0;
        stall_e_o     = 1'b0;
        flush_d_o     = 1'b0;
        flush_e_o     = 1'b0;
        flush_m_o     = 1'b0;
        div_busy_o    = 1'b0;
        div_done_o    = 1'b0;
        if (rst_i) begin
            flush_d_o = 1'b1;
            flush_e_o = 1'b1;
            flush_m_o = 1'b1;
        end else begin
            forward_a_e_o = fwd_select(rs1_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
            forward_b_e_o = fwd_select(rs2_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
            stall_f_o     = lw_stall_s | div_stall_s;
            stall_d_o     = lw_stall_s | div_stall_s;
            stall_e_o     = div_stall_s;
            flush_d_o     = pc_src_e_i;
            // A frozen E stage holds the divide and must never be bubbled.
            flush_e_o     = (lw_stall_s | pc_src_e_i) & ~div_stall_s;
            flush_m_o     = div_stall_s;
            div_busy_o    = div_stall_s;
            div_done_o    = div_done_s;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed literal checks plus random
// traffic compared every cycle against a cycle-age reference model.
module tb_hazard_unit;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       we_m, we_w, load_e, pc_src, div_e;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, busy, done;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    // Cycles already spent in the current divide sequence (0 = none running).
    int phase   = 0;

    hazard_unit #(.DIV_CYCLES(D)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rs1_e_i(rs1_e), .rs2_e_i(rs2_e),
        .rd_e_i(rd_e), .rd_m_i(rd_m), .rd_w_i(rd_w),
        .reg_write_m_i(we_m), .reg_write_w_i(we_w),
        .load_e_i(load_e), .pc_src_e_i(pc_src), .div_e_i(div_e),
        .forward_a_e_o(fwd_a), .forward_b_e_o(fwd_b),
        .stall_f_o(stall_f), .stall_d_o(stall_d), .stall_e_o(stall_e),
        .flush_d_o(flush_d), .flush_e_o(flush_e), .flush_m_o(flush_m),
        .div_busy_o(busy), .div_done_o(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (we_m && rs == rd_m) return 2'b10;
        if (we_w && rs == rd_w) return 2'b01;
        return 2'b00;
    endfunction

    // Reference model state: divide sequence age advanced on each edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_i)               phase <= 0;
        else if (phase == 0)     phase <= div_e ? 1 : 0;
        else if (phase == D)     phase <= 0;
        else                     phase <= phase + 1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic lw, ds, dn;
        assert (!(load_e && pc_src) && !(load_e && div_e) && !(pc_src && div_e))
            else $error("E-stage kinds not exclusive");
        lw = load_e && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d);
        ds = !rst_i && ((phase == 0 && div_e) || (phase >= 1 && phase <= D - 1));
        dn = !rst_i && phase == D;
        if (rst_i) begin
            check("rst_stalls", {stall_f, stall_d, stall_e}, 3'b000);
            check("rst_flushes", {flush_d, flush_e, flush_m}, 3'b111);
            check("rst_fwd", {fwd_a, fwd_b}, 4'b0000);
            check("rst_div", {busy, done}, 2'b00);
        end else begin
            check("fwd_a", fwd_a, exp_fwd(rs1_e));
            check("fwd_b", fwd_b, exp_fwd(rs2_e));
            check("stall_fde", {stall_f, stall_d, stall_e}, {lw | ds, lw | ds, ds});
            check("flush_dem", {flush_d, flush_e, flush_m}, {pc_src, (lw | pc_src) & !ds, ds});
            check("div_bd", {busy, done}, {ds, dn});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
        {we_m, we_w, load_e, pc_src, div_e} = '0;
    endtask

    initial begin
        clear_in();
        rst_i = 1'b1;
        @(negedge clk);
        check("lit_rst", {stall_f, stall_e, flush_d, flush_e, flush_m, busy, done}, 7'b0011100);
        step(); step();
        rst_i = 1'b0;

        // Forwarding priority.
        rs1_e = 5'd5; rd_m = 5'd5; we_m = 1'b1; rd_w = 5'd5; we_w = 1'b1;
        @(negedge clk); check("lit_fwd_m", fwd_a, 2'b10);
        step(); we_m = 1'b0;
        @(negedge clk); check("lit_fwd_w", fwd_a, 2'b01);
        step(); rs1_e = 5'd0;
        @(negedge clk); check("lit_fwd_x0", fwd_a, 2'b00);
        step(); rs2_e = 5'd3; rd_w = 5'd3;
        @(negedge clk); check("lit_fwd_b_w", fwd_b, 2'b01);

        // Load-use.
        step(); clear_in(); load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
        @(negedge clk); check("lit_lw", {stall_f, stall_d, flush_e, stall_e}, 4'b1110);
        step(); rd_e = 5'd0; rs2_d = 5'd0;
        @(negedge clk); check("lit_lw_x0", {stall_f, stall_d, flush_e, stall_e}, 4'b0000);

        // Taken branch.
        step(); clear_in(); pc_src = 1'b1;
        @(negedge clk); check("lit_br", {flush_d, flush_e, stall_f, stall_d, stall_e}, 5'b11000);

        // Back-to-back divides with div_e held high.
        step(); clear_in(); div_e = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check("lit_div_stall", {stall_f, stall_e, flush_m, busy},
                  (c == 5 || c == 10) ? 4'b0000 : 4'b1111);
            check("lit_div_flush_e", flush_e, 1'b0);
            check("lit_div_done", done, (c == 5 || c == 10) ? 1'b1 : 1'b0);
            step();
        end
        div_e = 1'b0;

        // Reset in cycle 2 of a divide aborts it.
        step(); div_e = 1'b1;
        step(); rst_i = 1'b1; div_e = 1'b0;
        @(negedge clk); check("lit_rst_mid", {stall_f, stall_e, flush_d, flush_e, flush_m}, 5'b00111);
        step(); rst_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); check("lit_abort", {busy, done}, 2'b00);
            step();
        end

        // Random traffic; a running divide stays in E until its done cycle.
        for (int i = 0; i < 3000; i++) begin
            int kind;
            rs1_d = 5'($urandom_range(0, 7)); rs2_d = 5'($urandom_range(0, 7));
            rs1_e = 5'($urandom_range(0, 7)); rs2_e = 5'($urandom_range(0, 7));
            rd_e  = 5'($urandom_range(0, 7)); rd_m  = 5'($urandom_range(0, 7));
            rd_w  = 5'($urandom_range(0, 7));
            we_m  = 1'($urandom_range(0, 1)); we_w  = 1'($urandom_range(0, 1));
            kind  = (phase != 0 && phase != D) ? 3 : int'($urandom_range(0, 5));
            load_e = (kind == 1);
            pc_src = (kind == 2);
            div_e  = (kind == 3);
            rst_i  = ($urandom_range(0, 59) == 0);
            step();
        end
        clear_in(); rst_i = 1'b0;
        step(); step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Central hazard controller for the five-stage RV32 pipeline: produces the stall, flush and forwarding selects that drive the F/D, D/E (its `clr_i`) and E/M pipeline registers. Forwarding and load-use/branch detection are combinational. A small FSM with a down-counter freezes the front of the pipeline while a multi-cycle M-extension divide/remainder occupies the Execute stage.

## Interface
- `DIV_CYCLES`, default 32: number of stall cycles for a div/rem op in E; legal range ≥ 2.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `rs1_d_i`, `rs2_d_i` in 5 each: source registers of the instruction in D.
- `rs1_e_i`, `rs2_e_i`, `rd_e_i` in 5 each: sources and destination of the instruction in E.
- `rd_m_i`, `rd_w_i` in 5 each: destinations in M and W.
- `reg_write_m_i`, `reg_write_w_i` in 1 each: register-write enables for M and W.
- `load_e_i` in 1: instruction in E is a load (result_src == memory).
- `pc_src_e_i` in 1: taken branch or jump resolved in E.
- `div_e_i` in 1: instruction in E is DIV/DIVU/REM/REMU.
- `forward_a_e_o`, `forward_b_e_o` out 2 each: ALU operand select. 00 = register file, 10 = M ALU result, 01 = W result.
- `stall_f_o`, `stall_d_o`, `stall_e_o` out 1 each: hold the PC, F/D and D/E registers.
- `flush_d_o`, `flush_e_o`, `flush_m_o` out 1 each: clear F/D, D/E and E/M to a bubble.
- `div_busy_o` out 1: divide stall in progress.
- `div_done_o` out 1: single-cycle pulse; the divider result is consumed and E advances.

## Operation
- Forwarding, operand A:
  - `rs1_e_i != 0 && rs1_e_i == rd_m_i && reg_write_m_i` → 10.
  - Else `rs1_e_i != 0 && rs1_e_i == rd_w_i && reg_write_w_i` → 01.
  - Else 00.
  - M has priority over W. Operand B uses `rs2_e_i` with the same rules.
- Load-use: `lw_stall = load_e_i && rd_e_i != 0 && (rd_e_i == rs1_d_i || rd_e_i == rs2_d_i)`.
  - Asserts `stall_f_o`, `stall_d_o`, `flush_e_o`.
- Control hazard: `pc_src_e_i` → `flush_d_o` and `flush_e_o`.
- Divide FSM states: IDLE, BUSY, DONE. Counter `cnt` is `$clog2(DIV_CYCLES)` bits wide.
  - IDLE: if `div_e_i`, then `div_stall = 1`, `cnt <= DIV_CYCLES-2`, go to BUSY. Otherwise stay in IDLE.
  - BUSY: `div_stall = 1`. If `cnt == 0`, go to DONE; else `cnt <= cnt-1`.
  - DONE: `div_stall = 0`, `div_done_o = 1`, go to IDLE unconditionally. A div still present in E during DONE must not retrigger.
- `div_stall` asserts `stall_f_o`, `stall_d_o`, `stall_e_o`, `flush_m_o`, and `div_busy_o`.
- Output merge:
  - `stall_f_o = stall_d_o = lw_stall | div_stall`
  - `stall_e_o = div_stall`
  - `flush_d_o = pc_src_e_i`
  - `flush_e_o = lw_stall | pc_src_e_i`, but forced to 0 when `div_stall` (a frozen E must not be cleared).
  - `flush_m_o = div_stall`
- `lw_stall`, `pc_src_e_i` and `div_e_i` are mutually exclusive by construction (one instruction in E). The bench checks this with an assertion; the RTL does not arbitrate.
- Back-to-back divides: DONE → IDLE, and the next div now in E triggers a new sequence immediately.

## Timing
- Forwarding, load-use and branch outputs are combinational, valid in the same cycle as their inputs.
- Divide stall:
  - Stall outputs high for exactly `DIV_CYCLES` consecutive cycles, starting the cycle `div_e_i` first rises.
  - `div_done_o` pulses in cycle `DIV_CYCLES+1`.
  - The div occupies E for `DIV_CYCLES+1` cycles total.
- Reset:
  - Registered state after the reset edge: state = IDLE, `cnt` = 0.
  - While `rst_i` is high: all `stall_*` = 0, `flush_d_o` = `flush_e_o` = `flush_m_o` = 1, `forward_*` = 00, `div_busy_o` = `div_done_o` = 0.
  - Reset mid-BUSY aborts the sequence. No `div_done_o` is produced.

## Structure
- `hazard_pkg`:
  - `fwd_sel_t` enum {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10}.
  - `div_state_t` enum {IDLE, BUSY, DONE}.
- Sub-module `div_stall_fsm`: owns the state, counter, `div_stall` and `div_done_o`.
- Forwarding and load-use logic stay in the `hazard_unit` top.

## Test plan
- `rs1_e=5`; `rd_m=5`, `reg_write_m=1`; `rd_w=5`, `reg_write_w=1` → `forward_a=10`. Drop `reg_write_m` → 01. Set `rs1_e=0` → 00.
- `load_e=1`, `rd_e=7`, `rs2_d=7` → `stall_f`, `stall_d`, `flush_e` = 1, `stall_e` = 0. Set `rd_e=0` → all 0.
- `pc_src_e=1` → `flush_d` = `flush_e` = 1, no stalls.
- `DIV_CYCLES=4`, `div_e` held high:
  - Stalls and `flush_m` high for cycles 1–4, `flush_e` = 0.
  - `div_done` pulses in cycle 5.
  - Two consecutive divs → 4 stall cycles, 1 done, 4 stall cycles, 1 done.
- Assert `rst_i` in cycle 2 of a divide → next cycle state IDLE, `div_busy=0`, no `div_done`. During reset: flushes = 1, stalls = 0.
